// File: rtl/deser_align_pkg.sv
// Shared types and constants for the deserializer word-alignment controller.
package deser_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Phase/beat counter width; a ratio of 1 would otherwise give a zero-width counter.
  function automatic int phase_bits(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  localparam int DEFAULT_S = 8;
  localparam int PHASE_W = phase_bits(DEFAULT_S);
  localparam logic [63:0] DEFAULT_TRAIN_PATTERN = 64'h0706050403020100;

endpackage

// File: rtl/deser_phase_gen.sv
// Free-running beat counter and the capture strobe for the selected phase.
module deser_phase_gen
  import deser_align_pkg::*;
#(
  parameter int S  = 8,
  parameter int PW = phase_bits(S)
) (
  input  logic          high_speed_clock,
  input  logic          reset,
  input  logic [PW-1:0] phase,
  output logic          strobe,
  output logic [PW-1:0] beat_cnt
);

  localparam logic [PW-1:0] LAST_BEAT = PW'(S - 1);

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (beat_cnt == LAST_BEAT) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign strobe = (beat_cnt == phase);

endmodule

// File: rtl/deser_align_ctrl.sv
// Word-alignment controller: slips the capture phase until TRAIN_PATTERN is seen LOCK_COUNT times.
// Optional DESER_ALIGN_TIMEOUT_EN adds a sweep counter and the FAIL state.
module deser_align_ctrl
  import deser_align_pkg::*;
#(
  parameter int D = 8,
  parameter int S = 8,
  parameter logic [D*S-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int LOCK_COUNT = 4
`ifdef DESER_ALIGN_TIMEOUT_EN
  ,
  parameter int MAX_SWEEPS = 3
`endif
) (
  input  logic                    high_speed_clock,
  input  logic                    reset,
  input  logic [D*S-1:0]          deser_word,
  input  logic                    train_start,
  output logic [D*S-1:0]          data_out,
  output logic                    data_valid,
  output logic                    aligned,
  output logic                    align_error,
  output logic [phase_bits(S)-1:0] phase,
  output logic [2:0]              state_dbg,
  output logic [phase_bits(S)-1:0] beat_dbg
);

  localparam int PW = phase_bits(S);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(S - 1);
  localparam logic [MW-1:0] LOCK_LAST  = MW'(LOCK_COUNT - 1);

  // data_valid is a one-cycle qualifier with no backpressure: the consumer
  // must take data_out in the cycle data_valid is high.
  state_t        state;
  logic [PW-1:0] fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [PW-1:0] beat_cnt;
  logic          strobe;
  logic          pattern_hit;
  logic          capture_state;

`ifdef DESER_ALIGN_TIMEOUT_EN
  localparam int SW = $clog2(MAX_SWEEPS + 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(MAX_SWEEPS - 1);
  logic [SW-1:0] sweep_cnt;
`endif

  deser_phase_gen #(.S(S), .PW(PW)) u_phase_gen (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .phase            (phase),
    .strobe           (strobe),
    .beat_cnt         (beat_cnt)
  );

  assign pattern_hit   = (deser_word == TRAIN_PATTERN);
  assign capture_state = (state == ST_FILL) || (state == ST_CHECK) || (state == ST_LOCKED);

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      fill_cnt   <= '0;
      match_cnt  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef DESER_ALIGN_TIMEOUT_EN
      sweep_cnt  <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (train_start) begin
        // A (re)start discards any strobe in the same cycle.
        state     <= ST_FILL;
        phase     <= '0;
        fill_cnt  <= '0;
        match_cnt <= '0;
`ifdef DESER_ALIGN_TIMEOUT_EN
        sweep_cnt <= '0;
`endif
      end else begin
        if (strobe && capture_state) data_out <= deser_word;
        if (strobe && (state == ST_LOCKED)) data_valid <= 1'b1;
        case (state)
          ST_FILL: begin
            if (fill_cnt == LAST_PHASE) state <= ST_CHECK;
            else fill_cnt <= fill_cnt + 1'b1;
          end
          ST_CHECK: begin
            if (strobe) begin
              if (pattern_hit) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == LOCK_LAST) state <= ST_LOCKED;
              end else begin
                match_cnt <= '0;
                if (phase == LAST_PHASE) begin
                  phase <= '0;
`ifdef DESER_ALIGN_TIMEOUT_EN
                  sweep_cnt <= sweep_cnt + 1'b1;
                  if (sweep_cnt == SWEEP_LAST) state <= ST_FAIL;
`endif
                end else begin
                  phase <= phase + 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign aligned   = (state == ST_LOCKED);
  assign state_dbg = state;
  assign beat_dbg  = beat_cnt;

`ifdef DESER_ALIGN_TIMEOUT_EN
  assign align_error = (state == ST_FAIL);
`else
  assign align_error = 1'b0;
`endif

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Scoreboard bench for deser_align_ctrl (D=8, S=8, LOCK_COUNT=2); stream bytes 00..07 synthesized per beat.
module tb_deser_align_ctrl;
  import deser_align_pkg::*;

  localparam logic [63:0] PATTERN = 64'h0706050403020100;

  logic        high_speed_clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] deser_word = '0;
  logic        train_start = 1'b0;
  logic [63:0] data_out;
  logic        data_valid;
  logic        aligned;
  logic        align_error;
  logic [2:0]  phase;
  logic [2:0]  state_dbg;
  logic [2:0]  beat_dbg;

  deser_align_ctrl #(.D(8), .S(8), .LOCK_COUNT(2)) dut (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .deser_word       (deser_word),
    .train_start      (train_start),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .aligned          (aligned),
    .align_error      (align_error),
    .phase            (phase),
    .state_dbg        (state_dbg),
    .beat_dbg         (beat_dbg)
  );

  // clock / reset
  always #5 high_speed_clock = ~high_speed_clock;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // scenario knobs
  int cyc = 0;
  int k_align = 5;
  bit ff_mode = 1'b0;
  int corrupt_cyc = -1;
  int ts2_cyc = -1;
  int rst_cyc = -1;
  int vbeat = 5;
  int lo1 = -1, hi1 = -2, lo2 = -1, hi2 = -2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] gen(input int c);
    logic [63:0] w;
    int b;
    b = c % 8;
    if (ff_mode) return {8{8'hFF}};
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'((b + 8 - k_align + i) % 8);
    if (c == corrupt_cyc) w[31:24] = w[31:24] ^ 8'h80;
    return w;
  endfunction

  // driver
  task automatic drive();
    reset       = (cyc == rst_cyc);
    train_start = (cyc == 0) || (cyc == ts2_cyc);
    deser_word  = gen(cyc);
    if ((cyc % 8 == vbeat) && ((cyc >= lo1 && cyc <= hi1) || (cyc >= lo2 && cyc <= hi2)))
      exp_q.push_back(PATTERN);
  endtask

  task automatic step();
    @(negedge high_speed_clock);
    cyc++;
    drive();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic begin_scenario(input int k, input bit ff, input int corrupt, input int vb,
                                input int l1, input int h1, input int l2, input int h2,
                                input int ts2, input int rc);
    @(negedge high_speed_clock);
    reset = 1'b1;
    train_start = 1'b0;
    k_align = k; ff_mode = ff; corrupt_cyc = corrupt; vbeat = vb;
    lo1 = l1; hi1 = h1; lo2 = l2; hi2 = h2; ts2_cyc = ts2; rst_cyc = rc;
    repeat (2) @(negedge high_speed_clock);
    cyc = 0;
    drive();
  endtask

  // monitor / scoreboard
  always @(negedge high_speed_clock) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid at cycle %0d: got data_out %h expected no pulse", cyc, data_out);
      end else begin
        check("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Lock at phase 5, then coincident restart, re-lock, reset while locked.
    begin_scenario(5, 1'b0, -1, 5, 37, 61, 101, 109, 69, 111);
    check("rst_aligned", 64'(aligned), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_beat", 64'(beat_dbg), 64'd0);
    check("rst_align_error", 64'(align_error), 64'd0);
    run_to(20);
    check("s1_phase_before_last_slip", 64'(phase), 64'd4);
    run_to(21);
    check("s1_phase_slipped", 64'(phase), 64'd5);
    run_to(29);
    check("s1_not_yet_aligned", 64'(aligned), 64'd0);
    run_to(30);
    check("s1_aligned", 64'(aligned), 64'd1);
    check("s1_phase_locked", 64'(phase), 64'd5);
    run_to(69);
    check("s1_aligned_at_restart", 64'(aligned), 64'd1);
    check("s1_queue_drained", 64'(exp_q.size()), 64'd0);
    run_to(70);
    check("restart_aligned_low", 64'(aligned), 64'd0);
    check("restart_phase", 64'(phase), 64'd0);
    check("restart_state", 64'(state_dbg), 64'(ST_FILL));
    run_to(94);
    check("relock_aligned", 64'(aligned), 64'd1);
    run_to(112);
    check("lk_rst_aligned", 64'(aligned), 64'd0);
    check("lk_rst_valid", 64'(data_valid), 64'd0);
    check("lk_rst_data_out", data_out, 64'd0);
    check("lk_rst_phase", 64'(phase), 64'd0);
    check("lk_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("lk_rst_beat", 64'(beat_dbg), 64'd0);
    run_to(140);
    check("lk_rst_stays_idle", 64'(aligned), 64'd0);
    check("s1_final_queue", 64'(exp_q.size()), 64'd0);

    // Pattern already aligned at beat 0: no slips.
    begin_scenario(0, 1'b0, -1, 0, 32, 40, -1, -2, -1, -1);
    run_to(24);
    check("s2_not_yet_aligned", 64'(aligned), 64'd0);
    check("s2_phase", 64'(phase), 64'd0);
    run_to(25);
    check("s2_aligned", 64'(aligned), 64'd1);
    check("s2_phase_locked", 64'(phase), 64'd0);
    run_to(44);
    check("s2_queue_drained", 64'(exp_q.size()), 64'd0);

    // Corrupted byte after the first match: count clears, phase slips, re-lock later.
    begin_scenario(5, 1'b0, 29, 5, 53, 61, -1, -2, -1, -1);
    run_to(30);
    check("s4_phase_slip", 64'(phase), 64'd6);
    check("s4_not_aligned", 64'(aligned), 64'd0);
    run_to(45);
    check("s4_no_early_lock", 64'(aligned), 64'd0);
    run_to(46);
    check("s4_aligned", 64'(aligned), 64'd1);
    check("s4_phase", 64'(phase), 64'd5);
    run_to(64);
    check("s4_queue_drained", 64'(exp_q.size()), 64'd0);

    // Constant 0xFF stream: never matches.
    begin_scenario(0, 1'b1, -1, 0, -1, -2, -1, -2, -1, -1);
    run_to(39);
    check("ff_no_error_yet", 64'(align_error), 64'd0);
    run_to(40);
`ifdef DESER_ALIGN_TIMEOUT_EN
    check("ff_align_error", 64'(align_error), 64'd1);
    check("ff_state", 64'(state_dbg), 64'(ST_FAIL));
`else
    check("ff_no_align_error", 64'(align_error), 64'd0);
    check("ff_phase_wrapped", 64'(phase), 64'd0);
    run_to(43);
    check("ff_phase_cycling", 64'(phase), 64'd3);
`endif
    run_to(60);
    check("ff_not_aligned", 64'(aligned), 64'd0);
    check("ff_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
